// File: rtl/nts_tx_pkg.sv
// Shared types and helpers for the NTS TX MAC framer: FSM state encoding,
// the skid-buffer entry layout and the last-word byte conversion functions.
package nts_tx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      ACK,
      GAP
   } tx_state_e;

   localparam int BYTES_PER_WORD = 8;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  mask;
      logic        last;
   } tx_beat_t;

   // A byte count of 0 or above 8 means a full word.
   function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
      logic [3:0] c;
      if (n == 4'd0 || n > 4'(BYTES_PER_WORD)) begin
         c = 4'(BYTES_PER_WORD);
      end else begin
         c = n;
      end
      return c;
   endfunction

   // n valid bytes -> LSB-justified byte-valid mask.
   function automatic logic [7:0] bytes_to_mask(input logic [3:0] n);
      return 8'hFF >> (4'(BYTES_PER_WORD) - clamp_bytes(n));
   endfunction

   // Move the n MSB-justified bytes of a network-order word down to the LSBs.
   function automatic logic [63:0] right_justify(input logic [63:0] data,
                                                 input logic [3:0]  n);
      logic [3:0] drop;
      drop = 4'(BYTES_PER_WORD) - clamp_bytes(n);
      return data >> {drop, 3'b000};
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] m);
      logic [3:0] c;
      c = 4'd0;
      for (int i = 0; i < 8; i++) begin
         c = c + {3'b000, m[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/nts_tx_skid_buffer.sv
// Two-entry FIFO between the engine read port and the MAC. Entry 0 is the
// head and drives the MAC outputs directly, so the beat is always registered.
module nts_tx_skid_buffer
   import nts_tx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_areset_n,
   input  logic       push,
   input  tx_beat_t   push_beat,
   input  logic       pop,
   output tx_beat_t   head,
   output logic       head_valid,
   output logic [1:0] occupancy
);

   tx_beat_t   entry0;
   tx_beat_t   entry1;
   logic [1:0] count;
   logic       pop_ok;
   logic [1:0] wr_slot;

   assign pop_ok  = pop && (count != 2'd0);
   assign wr_slot = count - {1'b0, pop_ok};

   // Shift on pop, then write the incoming word into the first free slot
   // (the later non-blocking write wins when both touch entry 0).
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         entry0 <= '0;
         entry1 <= '0;
         count  <= 2'd0;
      end else begin
         if (pop_ok) begin
            entry0 <= entry1;
         end
         if (push) begin
            if (wr_slot == 2'd0) begin
               entry0 <= push_beat;
            end else begin
               entry1 <= push_beat;
            end
         end
         count <= count + {1'b0, push} - {1'b0, pop_ok};
      end
   end

   assign head       = entry0;
   assign head_valid = (count != 2'd0);
   assign occupancy  = count;

endmodule

// File: rtl/nts_tx_mac_framer.sv
// NTS TX MAC framer: drains one finished packet from the engine TX buffer,
// streams it to the 64-bit MAC with ready/valid, right-justifies the last
// word, acknowledges the engine and then holds an inter-frame gap.
// Optional statistics counters are built only when NTS_TX_STATS_EN is defined.
module nts_tx_mac_framer
   import nts_tx_pkg::*;
#(
   parameter int MAC_DATA_WIDTH = 64,
   parameter int IFG_CYCLES     = 2
)
(
   input  logic                      i_clk,
   input  logic                      i_areset_n,
   input  logic                      i_dispatch_tx_packet_available,
   output logic                      o_dispatch_tx_packet_read,
   input  logic                      i_dispatch_tx_fifo_empty,
   output logic                      o_dispatch_tx_fifo_rd_en,
   input  logic [MAC_DATA_WIDTH-1:0] i_dispatch_tx_fifo_rd_data,
   input  logic [3:0]                i_dispatch_tx_bytes_last_word,
   output logic [MAC_DATA_WIDTH-1:0] o_mac_tx_data,
   output logic [7:0]                o_mac_tx_data_valid,
   output logic                      o_mac_tx_last,
   input  logic                      i_mac_tx_ready,
   output logic                      o_busy,
   output logic [31:0]               o_stat_frames,
   output logic [31:0]               o_stat_bytes
);

   localparam logic [3:0] GAP_LAST = 4'(IFG_CYCLES - 1);

   tx_state_e  state;
   tx_state_e  next_state;
   logic [3:0] gap_cnt;
   logic       rd_pending;
   logic       last_seen;
   logic       rd_en;
   logic       packet_read;
   logic       arriving_last;
   logic       beat_accept;
   logic [1:0] credit_used;
   tx_beat_t   push_beat;
   tx_beat_t   head;
   logic       head_valid;
   logic [1:0] occupancy;

   assign beat_accept   = head_valid && i_mac_tx_ready;
   assign arriving_last = rd_pending && i_dispatch_tx_fifo_empty;

   // Slots already committed once this cycle's accepted beat has left;
   // counting the freed slot keeps back-to-back beats without gaps.
   assign credit_used = occupancy - {1'b0, beat_accept} + {1'b0, rd_pending};

   // Format the word returning from the engine; only the last one is shifted.
   always_comb begin
      push_beat.data = i_dispatch_tx_fifo_rd_data;
      push_beat.mask = 8'hFF;
      push_beat.last = 1'b0;
      if (arriving_last) begin
         push_beat.data = right_justify(i_dispatch_tx_fifo_rd_data,
                                        i_dispatch_tx_bytes_last_word);
         push_beat.mask = bytes_to_mask(i_dispatch_tx_bytes_last_word);
         push_beat.last = 1'b1;
      end
   end

   nts_tx_skid_buffer u_skid (
      .i_clk      (i_clk),
      .i_areset_n (i_areset_n),
      .push       (rd_pending),
      .push_beat  (push_beat),
      .pop        (beat_accept),
      .head       (head),
      .head_valid (head_valid),
      .occupancy  (occupancy)
   );

   // State register plus read tracking and gap counter.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         state      <= IDLE;
         gap_cnt    <= 4'd0;
         rd_pending <= 1'b0;
         last_seen  <= 1'b0;
      end else begin
         state      <= next_state;
         rd_pending <= rd_en;
         gap_cnt    <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
         if (state != STREAM) begin
            last_seen <= 1'b0;
         end else if (arriving_last) begin
            last_seen <= 1'b1;
         end
      end
   end

   // Next-state logic, engine read issue and acknowledge pulse.
   always_comb begin
      next_state  = state;
      rd_en       = 1'b0;
      packet_read = 1'b0;
      case (state)
         IDLE: begin
            if (i_dispatch_tx_packet_available) begin
               next_state = i_dispatch_tx_fifo_empty ? ACK : STREAM;
            end
         end
         STREAM: begin
            rd_en = !i_dispatch_tx_fifo_empty && !last_seen &&
                    (credit_used < 2'd2);
            if (beat_accept && head.last) begin
               next_state = ACK;
            end
         end
         ACK: begin
            packet_read = 1'b1;
            next_state  = (IFG_CYCLES == 0) ? IDLE : GAP;
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign o_dispatch_tx_fifo_rd_en  = rd_en;
   assign o_dispatch_tx_packet_read = packet_read;
   assign o_busy                    = (state != IDLE);
   assign o_mac_tx_data             = head_valid ? head.data : '0;
   assign o_mac_tx_data_valid       = head_valid ? head.mask : 8'h00;
   assign o_mac_tx_last             = head_valid && head.last;

`ifdef NTS_TX_STATS_EN
   logic        frame_nonempty;
   logic [31:0] stat_frames;
   logic [31:0] stat_bytes;

   // Frames count on the acknowledge of a packet that carried data; bytes
   // count only beats the MAC actually accepted.
   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         frame_nonempty <= 1'b0;
         stat_frames    <= 32'd0;
         stat_bytes     <= 32'd0;
      end else begin
         if (state == IDLE) begin
            frame_nonempty <= i_dispatch_tx_packet_available &&
                              !i_dispatch_tx_fifo_empty;
         end
         if (state == ACK && frame_nonempty) begin
            stat_frames <= stat_frames + 32'd1;
         end
         if (beat_accept) begin
            stat_bytes <= stat_bytes + 32'(popcount8(head.mask));
         end
      end
   end

   assign o_stat_frames = stat_frames;
   assign o_stat_bytes  = stat_bytes;
`else
   assign o_stat_frames = 32'd0;
   assign o_stat_bytes  = 32'd0;
`endif

endmodule

// File: tb/tb_nts_tx_mac_framer.sv
// Scoreboard bench for nts_tx_mac_framer: a cycle-stepped engine model feeds
// packets, expected beats/acks are queued at stimulus time and a negedge
// monitor pops and compares them whenever the DUT presents a beat or ack.
module tb_nts_tx_mac_framer;

   localparam int IFG = 2;
`ifdef NTS_TX_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic        is_ack;
      logic [63:0] data;
      logic [7:0]  mask;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        areset_n;
   logic        avail;
   logic        packet_read;
   logic        fifo_empty;
   logic        rd_en;
   logic [63:0] rd_data;
   logic [3:0]  bytes_last;
   logic [63:0] mac_data;
   logic [7:0]  mac_valid;
   logic        mac_last;
   logic        mac_ready;
   logic        busy;
   logic [31:0] stat_frames;
   logic [31:0] stat_bytes;

   exp_t        exp_q[$];
   logic [63:0] eng_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   int          accepted = 0;
   int          reads = 0;
   int          ack_seen = 0;
   logic        held_valid = 1'b0;
   logic [63:0] held_data;
   logic [7:0]  held_mask;
   logic        held_last;
   logic        in_frame = 1'b0;
   logic        gap_check = 1'b0;
   int          gap_left = 0;
   exp_t        mon_e;

   logic        rd_latched = 1'b0;
   logic        ack_latched = 1'b0;
   logic        offer_req = 1'b0;
   int          ready_mode = 0;
   int          cyc = 0;

   nts_tx_mac_framer #(
      .MAC_DATA_WIDTH (64),
      .IFG_CYCLES     (IFG)
   ) dut (
      .i_clk                          (clk),
      .i_areset_n                     (areset_n),
      .i_dispatch_tx_packet_available (avail),
      .o_dispatch_tx_packet_read      (packet_read),
      .i_dispatch_tx_fifo_empty       (fifo_empty),
      .o_dispatch_tx_fifo_rd_en       (rd_en),
      .i_dispatch_tx_fifo_rd_data     (rd_data),
      .i_dispatch_tx_bytes_last_word  (bytes_last),
      .o_mac_tx_data                  (mac_data),
      .o_mac_tx_data_valid            (mac_valid),
      .o_mac_tx_last                  (mac_last),
      .i_mac_tx_ready                 (mac_ready),
      .o_busy                         (busy),
      .o_stat_frames                  (stat_frames),
      .o_stat_bytes                   (stat_bytes)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // One clock of the engine/MAC-side model: inputs change 1 after posedge,
   // the read strobe and ack are sampled just after negedge.
   task automatic step();
      @(posedge clk);
      #1;
      if (rd_latched && eng_q.size() > 0) begin
         rd_data = eng_q.pop_front();
      end else begin
         rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      fifo_empty = (eng_q.size() == 0);
      if (ack_latched) avail = 1'b0;
      if (offer_req) begin
         avail     = 1'b1;
         offer_req = 1'b0;
      end
      mac_ready = (ready_mode == 1) ? ((cyc % 3) == 0) : 1'b1;
      cyc++;
      @(negedge clk);
      #1;
      rd_latched  = rd_en;
      ack_latched = packet_read;
   endtask

   task automatic apply_stimulus(input logic [63:0] w0, input logic [63:0] w1,
                                 input logic [63:0] w2, input int nwords,
                                 input logic [3:0] nbytes);
      if (nwords > 0) eng_q.push_back(w0);
      if (nwords > 1) eng_q.push_back(w1);
      if (nwords > 2) eng_q.push_back(w2);
      bytes_last = nbytes;
      offer_req  = 1'b1;
   endtask

   task automatic push_beat(input logic [63:0] d, input logic [7:0] m,
                            input logic l);
      exp_q.push_back({1'b0, d, m, l});
   endtask

   task automatic push_ack();
      exp_q.push_back({1'b1, 64'h0, 8'h00, 1'b0});
   endtask

   task automatic wait_ack(input string name);
      int base;
      int n;
      base = ack_seen;
      n = 0;
      while (ack_seen == base && n < 300) begin
         step();
         n++;
      end
      check_output({name, " ack seen"}, 64'(ack_seen != base), 64'd1);
      repeat (IFG + 2) step();
   endtask

   task automatic check_all_zero(input string name);
      check_output({name, " data"}, mac_data, 64'h0);
      check_output({name, " valid"}, 64'(mac_valid), 64'h0);
      check_output({name, " last"}, 64'(mac_last), 64'h0);
      check_output({name, " rd_en"}, 64'(rd_en), 64'h0);
      check_output({name, " packet_read"}, 64'(packet_read), 64'h0);
      check_output({name, " busy"}, 64'(busy), 64'h0);
      check_output({name, " frames"}, 64'(stat_frames), 64'h0);
      check_output({name, " bytes"}, 64'(stat_bytes), 64'h0);
   endtask

   task automatic do_reset();
      areset_n = 1'b0;
      #1;
      check_all_zero("reset");
      exp_q.delete();
      eng_q.delete();
      avail       = 1'b0;
      rd_latched  = 1'b0;
      ack_latched = 1'b0;
      offer_req   = 1'b0;
      repeat (2) step();
      areset_n = 1'b1;
      repeat (2) step();
   endtask

   // Monitor: pops the scoreboard on every accepted beat and every ack, and
   // checks beat hold, gap-free streaming, in-flight reads and the IFG.
   always @(negedge clk) begin
      if (!areset_n) begin
         held_valid = 1'b0;
         in_frame   = 1'b0;
         reads      = 0;
         accepted   = 0;
         gap_check  = 1'b0;
      end else begin
         if (held_valid) begin
            check_output("hold data", mac_data, held_data);
            check_output("hold mask", 64'(mac_valid), 64'(held_mask));
            check_output("hold last", 64'(mac_last), 64'(held_last));
         end
         if (mac_valid != 8'h00) begin
            if (mac_ready) begin
               accepted++;
               if (exp_q.size() > 0) mon_e = exp_q.pop_front();
               else mon_e = {1'b1, 64'h0, 8'h00, 1'b0};
               check_output("beat kind", 64'd0, 64'(mon_e.is_ack));
               check_output("beat data", mac_data, mon_e.data);
               check_output("beat mask", 64'(mac_valid), 64'(mon_e.mask));
               check_output("beat last", 64'(mac_last), 64'(mon_e.last));
               held_valid = 1'b0;
               in_frame   = !mac_last;
            end else begin
               held_valid = 1'b1;
               held_data  = mac_data;
               held_mask  = mac_valid;
               held_last  = mac_last;
               in_frame   = 1'b1;
            end
         end else begin
            if (in_frame) check_output("beat gap", 64'(mac_valid != 8'h00), 64'd1);
            held_valid = 1'b0;
         end
         if (rd_en) begin
            reads++;
            check_output("in-flight over 2", 64'((reads - accepted) > 2), 64'd0);
         end
         if (packet_read) begin
            ack_seen++;
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else mon_e = {1'b0, 64'h0, 8'h00, 1'b0};
            check_output("ack kind", 64'd1, 64'(mon_e.is_ack));
            gap_check = 1'b1;
            gap_left  = IFG;
         end else if (gap_check) begin
            if (gap_left > 0) begin
               check_output("gap busy", 64'(busy), 64'd1);
               check_output("gap valid", 64'(mac_valid), 64'd0);
               check_output("gap rd_en", 64'(rd_en), 64'd0);
               gap_left--;
            end else begin
               check_output("post-gap busy", 64'(busy), 64'd0);
               gap_check = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      areset_n   = 1'b1;
      avail      = 1'b0;
      fifo_empty = 1'b1;
      rd_data    = 64'h0;
      bytes_last = 4'd0;
      mac_ready  = 1'b1;
      #2;
      do_reset();

      $display("[TB] 3-word packet, ready high");
      push_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
      push_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
      push_beat(64'h0000_0000_AABB_CCDD, 8'h0F, 1'b1);
      push_ack();
      apply_stimulus(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'hAABB_CCDD_0000_0000, 3, 4'd4);
      wait_ack("3word");

      $display("[TB] 3-word packet, ready toggling");
      ready_mode = 1;
      push_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
      push_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
      push_beat(64'h0000_0000_AABB_CCDD, 8'h0F, 1'b1);
      push_ack();
      apply_stimulus(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'hAABB_CCDD_0000_0000, 3, 4'd4);
      wait_ack("toggle");
      ready_mode = 0;

      $display("[TB] 1-word packets");
      push_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
      push_ack();
      apply_stimulus(64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 1, 4'd8);
      wait_ack("1word n8");
      push_beat(64'h0000_0000_0000_00A5, 8'h01, 1'b1);
      push_ack();
      apply_stimulus(64'hA5B6_C7D8_E9F0_0112, 64'h0, 64'h0, 1, 4'd1);
      wait_ack("1word n1");
      push_beat(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1);
      push_ack();
      apply_stimulus(64'hFEDC_BA98_7654_3210, 64'h0, 64'h0, 1, 4'd0);
      wait_ack("1word n0");

      $display("[TB] empty packet");
      push_ack();
      apply_stimulus(64'h0, 64'h0, 64'h0, 0, 4'd8);
      wait_ack("empty");

      $display("[TB] reset mid-frame");
      push_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
      push_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
      push_beat(64'h0000_0000_AABB_CCDD, 8'h0F, 1'b1);
      push_ack();
      apply_stimulus(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'hAABB_CCDD_0000_0000, 3, 4'd4);
      begin
         int n;
         n = 0;
         while (accepted < 2 && n < 100) begin
            step();
            n++;
         end
         check_output("two beats before reset", 64'(accepted >= 2), 64'd1);
      end
      do_reset();
      repeat (4) step();
      push_beat(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
      push_beat(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
      push_beat(64'h0000_0000_AABB_CCDD, 8'h0F, 1'b1);
      push_ack();
      apply_stimulus(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                     64'hAABB_CCDD_0000_0000, 3, 4'd4);
      wait_ack("replay");

      $display("[TB] statistics: 20-byte, empty, 13-byte frames");
      do_reset();
      push_beat(64'h0102_0304_0506_0708, 8'hFF, 1'b0);
      push_beat(64'h1112_1314_1516_1718, 8'hFF, 1'b0);
      push_beat(64'h0000_0000_2122_2324, 8'h0F, 1'b1);
      push_ack();
      apply_stimulus(64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                     64'h2122_2324_0000_0000, 3, 4'd4);
      wait_ack("stats f1");
      check_output("frames after f1", 64'(stat_frames), STATS ? 64'd1 : 64'd0);
      check_output("bytes after f1", 64'(stat_bytes), STATS ? 64'd20 : 64'd0);
      push_ack();
      apply_stimulus(64'h0, 64'h0, 64'h0, 0, 4'd8);
      wait_ack("stats empty");
      check_output("frames after empty", 64'(stat_frames), STATS ? 64'd1 : 64'd0);
      check_output("bytes after empty", 64'(stat_bytes), STATS ? 64'd20 : 64'd0);
      push_beat(64'h3132_3334_3536_3738, 8'hFF, 1'b0);
      push_beat(64'h0000_0041_4243_4445, 8'h1F, 1'b1);
      push_ack();
      apply_stimulus(64'h3132_3334_3536_3738, 64'h4142_4344_4500_0000,
                     64'h0, 2, 4'd5);
      wait_ack("stats f2");
      check_output("frames after f2", 64'(stat_frames), STATS ? 64'd2 : 64'd0);
      check_output("bytes after f2", 64'(stat_bytes), STATS ? 64'd33 : 64'd0);

      check_output("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
